// File: rtl/brpred_gshare.sv
// Gshare branch predictor: saturating counters indexed by PC XOR global history (bimodal when GHR_W=0).
// Optional feature macro BRPRED_STATS_EN adds branch / mispredict statistics counters.
module brpred_gshare #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int GHR_W = 4,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  input  logic             if_branch,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             stall,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict
`ifdef BRPRED_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] table_q [ENTRIES];
  logic [CNT_W-1:0] cnt_cur_s;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] ghr_ext_s;
  logic             upd_en_s;
  logic             unused_pc_s;

  assign upd_en_s    = upd_valid & ~stall;
  assign unused_pc_s = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_q;
      logic [GHR_W-1:0] ghr_d;
      logic [GHR_W:0]   ghr_shift_s;

      assign ghr_shift_s = {ghr_q, upd_taken};
      assign ghr_ext_s   = IDX_W'(ghr_q);

      // History advances only on resolved, non-stalled branches.
      always_comb begin
        ghr_d = ghr_q;
        if (upd_en_s) begin
          ghr_d = ghr_shift_s[GHR_W-1:0];
        end else begin
          ghr_d = ghr_q;
        end
      end

      // Global history register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ghr_q <= {GHR_W{1'b0}};
        end else begin
          ghr_q <= ghr_d;
        end
      end
    end else begin : g_bimodal
      assign ghr_ext_s = {IDX_W{1'b0}};
    end
  endgenerate

  assign pred_idx   = if_pc[IDX_W+1:2] ^ ghr_ext_s;
  assign pred_taken = if_branch & table_q[pred_idx][CNT_W-1];
  assign mispredict = upd_valid & (upd_taken != upd_pred);
  assign cnt_cur_s  = table_q[upd_idx];

  // Saturating increment/decrement of the addressed counter.
  always_comb begin
    cnt_d = cnt_cur_s;
    if (upd_taken) begin
      cnt_d = (cnt_cur_s == CNT_MAX) ? cnt_cur_s : cnt_cur_s + CNT_W'(1);
    end else begin
      cnt_d = (cnt_cur_s == {CNT_W{1'b0}}) ? cnt_cur_s : cnt_cur_s - CNT_W'(1);
    end
  end

  // Counter table; queries in the update cycle still see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CNT_INIT;
      end
    end else if (upd_en_s) begin
      table_q[upd_idx] <= cnt_d;
    end
  end

`ifdef BRPRED_STATS_EN
  // Statistics counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= 32'd0;
      stat_mispred  <= 32'd0;
    end else if (upd_en_s) begin
      stat_branches <= stat_branches + 32'd1;
      stat_mispred  <= stat_mispred + {31'd0, mispredict};
    end
  end
`endif

endmodule

// File: tb/tb_brpred_gshare.sv
// Directed self-checking bench for brpred_gshare: one gshare instance (defaults) and one bimodal instance.
module tb_brpred_gshare;

  logic        clk;
  logic        rst_n;

  logic [31:0] pc_a;
  logic        br_a, stall_a, valid_a, taken_a, upred_a;
  logic [5:0]  uidx_a;
  logic        ptaken_a, misp_a;
  logic [5:0]  pidx_a;
`ifdef BRPRED_STATS_EN
  logic [31:0] sbr_a, smis_a;
`endif

  logic [31:0] pc_b;
  logic        br_b, stall_b, valid_b, taken_b, upred_b;
  logic [5:0]  uidx_b;
  logic        ptaken_b, misp_b;
  logic [5:0]  pidx_b;

  int passed;
  int total;

  brpred_gshare dut (
    .clk(clk), .rst_n(rst_n), .if_pc(pc_a), .if_branch(br_a),
    .pred_taken(ptaken_a), .pred_idx(pidx_a), .stall(stall_a),
    .upd_valid(valid_a), .upd_idx(uidx_a), .upd_taken(taken_a),
    .upd_pred(upred_a), .mispredict(misp_a)
`ifdef BRPRED_STATS_EN
    , .stat_branches(sbr_a), .stat_mispred(smis_a)
`endif
  );

  brpred_gshare #(.GHR_W(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_pc(pc_b), .if_branch(br_b),
    .pred_taken(ptaken_b), .pred_idx(pidx_b), .stall(stall_b),
    .upd_valid(valid_b), .upd_idx(uidx_b), .upd_taken(taken_b),
    .upd_pred(upred_b), .mispredict(misp_b)
`ifdef BRPRED_STATS_EN
    , .stat_branches(), .stat_mispred()
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic upd_a(input logic [5:0] idx, input logic tk, input logic pr, input logic st);
    uidx_a = idx; taken_a = tk; upred_a = pr; stall_a = st; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0; stall_a = 1'b0;
  endtask

  task automatic upd_b(input logic [5:0] idx, input logic tk, input logic st);
    uidx_b = idx; taken_b = tk; upred_b = 1'b0; stall_b = st; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0; stall_b = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; passed = 0; total = 0;
    pc_a = 32'd0; br_a = 1'b0; stall_a = 1'b0; valid_a = 1'b0; taken_a = 1'b0; upred_a = 1'b0; uidx_a = 6'd0;
    pc_b = 32'd0; br_b = 1'b0; stall_b = 1'b0; valid_b = 1'b0; taken_b = 1'b0; upred_b = 1'b0; uidx_b = 6'd0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state query
    pc_a = 32'h40; br_a = 1'b1; #1;
    check("reset_idx", 32'(pidx_a), 32'h10);
    check("reset_pred", 32'(ptaken_a), 32'd0);
    check("reset_misp", 32'(misp_a), 32'd0);

    // Mispredict is combinational on its inputs
    valid_a = 1'b1; taken_a = 1'b1; upred_a = 1'b0; #1;
    check("misp_diff", 32'(misp_a), 32'd1);
    upred_a = 1'b1; #1;
    check("misp_same", 32'(misp_a), 32'd0);
    valid_a = 1'b0; #1;

    // A stalled update must not shift the history
    upd_a(6'h3F, 1'b1, 1'b1, 1'b1);
    check("ghr_stall_hold", 32'(pidx_a), 32'h10);

    // History 1,0,1,1 -> 4'b1011
    upd_a(6'h3F, 1'b1, 1'b1, 1'b0);
    upd_a(6'h3F, 1'b0, 1'b0, 1'b0);
    upd_a(6'h3F, 1'b1, 1'b1, 1'b0);
    upd_a(6'h3F, 1'b1, 1'b1, 1'b0);
    #1;
    check("gshare_idx_40", 32'(pidx_a), 32'h1B);
    pc_a = 32'h44; #1;
    check("gshare_idx_44", 32'(pidx_a), 32'h1A);
    pc_a = 32'hD0; #1;
    check("gshare_idx_d0", 32'(pidx_a), 32'h3F);
    check("gshare_pred_3f", 32'(ptaken_a), 32'd1);

    // Oldest history bit drops: GHR becomes 4'b0110, counter 0x3F 11->10
    upd_a(6'h3F, 1'b0, 1'b1, 1'b0);
    pc_a = 32'h40; #1;
    check("ghr_shift_idx", 32'(pidx_a), 32'h16);
    pc_a = 32'hD0; #1;
    check("alias_pred_32", 32'(ptaken_a), 32'd0);
    pc_a = 32'hE4; #1;
    check("idx_3f_pred", 32'(ptaken_a), 32'd1);

    // Statistics from a fresh asynchronous reset
    #1 rst_n = 1'b0; #1;
    pc_a = 32'h40; #1;
    check("async_rst_idx", 32'(pidx_a), 32'h10);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    upd_a(6'h20, 1'b1, 1'b1, 1'b0);
    upd_a(6'h20, 1'b1, 1'b0, 1'b0);
    upd_a(6'h20, 1'b0, 1'b0, 1'b0);
    upd_a(6'h20, 1'b1, 1'b0, 1'b1);
    upd_a(6'h20, 1'b0, 1'b1, 1'b0);
    upd_a(6'h20, 1'b1, 1'b1, 1'b0);
`ifdef BRPRED_STATS_EN
    check("stat_branches", sbr_a, 32'd5);
    check("stat_mispred", smis_a, 32'd2);
    #2 rst_n = 1'b0; #1;
    check("stat_br_rst", sbr_a, 32'd0);
    check("stat_mis_rst", smis_a, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    // Bimodal: same-cycle update sees pre-update state
    pc_b = 32'h14; br_b = 1'b1; #1;
    check("bim_idx_5", 32'(pidx_b), 32'h05);
    uidx_b = 6'h05; taken_b = 1'b1; valid_b = 1'b1; #1;
    check("hazard_same_cycle", 32'(ptaken_b), 32'd0);
    @(posedge clk); #1;
    valid_b = 1'b0; #1;
    check("hazard_next_cycle", 32'(ptaken_b), 32'd1);

    // Bimodal training and saturation on idx 0x10
    pc_b = 32'h40; #1;
    check("bim_idx_10", 32'(pidx_b), 32'h10);
    upd_b(6'h10, 1'b1, 1'b0);
    check("train_t1", 32'(ptaken_b), 32'd1);
    upd_b(6'h10, 1'b1, 1'b0);
    upd_b(6'h10, 1'b1, 1'b0);
    upd_b(6'h10, 1'b0, 1'b0);
    check("sat_then_nt", 32'(ptaken_b), 32'd1);
    upd_b(6'h10, 1'b0, 1'b0);
    check("train_nt2", 32'(ptaken_b), 32'd0);

    // Stall gating: three stalled updates, then exactly one increment
    upd_b(6'h10, 1'b1, 1'b1);
    upd_b(6'h10, 1'b1, 1'b1);
    stall_b = 1'b1; valid_b = 1'b1; taken_b = 1'b1; upred_b = 1'b0; #1;
    check("stall_misp", 32'(misp_b), 32'd1);
    @(posedge clk); #1;
    valid_b = 1'b0; stall_b = 1'b0; #1;
    check("stall_hold", 32'(ptaken_b), 32'd0);
    upd_b(6'h10, 1'b1, 1'b0);
    check("stall_release", 32'(ptaken_b), 32'd1);
    br_b = 1'b0; #1;
    check("no_branch_pred", 32'(ptaken_b), 32'd0);
    br_b = 1'b1;
    upd_b(6'h10, 1'b0, 1'b0);
    check("single_inc", 32'(ptaken_b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
